alu_seq: RTL

- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Operand width is set by a parameter. Results are registered behind a valid/ready handshake, and the output holds a double-width result.
- Division is a multi-cycle restoring divider. The block also adds a variable shift amount, status flags and an error flag.
- Sits between the operand/issue logic and the writeback stage of the datapath.

---
 rtl/alu_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake and a multi-cycle
// restoring divider.
//
// Single-cycle ops (add, sub, mul, logic, shifts, compares, divide-by-zero,
// illegal) are registered on the accept edge. A divide with a non-zero
// divisor goes through the FSM IDLE -> DIV (WIDTH steps) -> DONE and
// presents its result WIDTH+1 cycles after the accept edge.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  operand handshake (in_ready is combinational)
//   a, b, op             operands and 4-bit op code, sampled on accept
//   out_valid/out_ready  result handshake
//   result               2*WIDTH result (zero-extended unless op widens it)
//   zero, carry, err     status flags, meaningful while out_valid=1
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               carry,
  output logic               err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_GT   = 4'b1010;
  localparam logic [3:0] OP_EQ   = 4'b1011;

  typedef enum logic [1:0] {IDLE = 2'b00, DIV = 2'b01, DONE = 2'b10} state_t;

  typedef struct packed {
    logic [2*WIDTH-1:0] res;
    logic               cy;
    logic               er;
  } calc_t;

  // Single-cycle result. A divide only reaches this path with a zero
  // divisor, so the DIV arm encodes the divide-by-zero convention.
  function automatic calc_t alu_calc(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [3:0]       o);
    calc_t              c;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] wide;
    c    = '{res: {(2*WIDTH){1'b0}}, cy: 1'b0, er: 1'b0};
    sum  = {(WIDTH+1){1'b0}};
    wide = {(2*WIDTH){1'b0}};
    case (o)
      OP_ADD: begin
        sum   = {1'b0, x} + {1'b0, y};
        c.res = {{(WIDTH-1){1'b0}}, sum};
        c.cy  = sum[WIDTH];
      end
      OP_SUB: begin
        sum   = {1'b0, x} - {1'b0, y};
        c.res = {{(WIDTH-1){1'b0}}, sum};
        c.cy  = sum[WIDTH];
      end
      OP_MUL:  c.res = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
      OP_DIV: begin
        c.res = {x, {WIDTH{1'b1}}};
        c.er  = 1'b1;
      end
      OP_AND:  c.res = {{WIDTH{1'b0}}, x & y};
      OP_OR:   c.res = {{WIDTH{1'b0}}, x | y};
      OP_XOR:  c.res = {{WIDTH{1'b0}}, x ^ y};
      OP_XNOR: c.res = {{WIDTH{1'b0}}, ~(x ^ y)};
      OP_SHL: begin
        wide  = {{WIDTH{1'b0}}, x} << y[SHW-1:0];
        c.res = wide;
        c.cy  = wide[WIDTH];
      end
      OP_SHR:  c.res = {{WIDTH{1'b0}}, x >> y[SHW-1:0]};
      OP_GT:   c.res = {{(2*WIDTH-1){1'b0}}, (x > y)};
      OP_EQ:   c.res = {{(2*WIDTH-1){1'b0}}, (x == y)};
      default: c.er  = 1'b1;
    endcase
    return c;
  endfunction

  state_t             state_r, state_next_s;
  logic [WIDTH-1:0]   quo_r, dvs_r, rem_r;
  logic [SHW-1:0]     cnt_r;
  logic               out_valid_r, zero_r, carry_r, err_r;
  logic [2*WIDTH-1:0] result_r;

  logic               in_ready_s, accept_s, start_div_s, ge_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH-1:0]   rem_next_s;
  calc_t              calc_s;

  assign in_ready_s  = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign start_div_s = accept_s && (op == OP_DIV) && (b != {WIDTH{1'b0}});
  assign calc_s      = alu_calc(a, b, op);

  // One restoring step: bring down the next dividend bit, subtract the
  // divisor if it fits. The difference is always < divisor, so WIDTH bits
  // of the subtraction are enough.
  assign shifted_s  = {rem_r, quo_r[WIDTH-1]};
  assign ge_s       = (shifted_s >= {1'b0, dvs_r});
  assign rem_next_s = ge_s ? (shifted_s[WIDTH-1:0] - dvs_r) : shifted_s[WIDTH-1:0];

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign carry     = carry_r;
  assign err       = err_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_div_s) state_next_s = DIV;
        else             state_next_s = IDLE;
      end
      DIV: begin
        if (cnt_r == LAST_CNT) state_next_s = DONE;
        else                   state_next_s = DIV;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Divider datapath: quo_r starts as the dividend and shifts quotient bits in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r <= {WIDTH{1'b0}};
      dvs_r <= {WIDTH{1'b0}};
      rem_r <= {WIDTH{1'b0}};
      cnt_r <= {SHW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_div_s) begin
            quo_r <= a;
            dvs_r <= b;
            rem_r <= {WIDTH{1'b0}};
            cnt_r <= {SHW{1'b0}};
          end else begin
            cnt_r <= cnt_r;
          end
        end
        DIV: begin
          quo_r <= {quo_r[WIDTH-2:0], ge_s};
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + SHW'(1'b1);
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Output register: load a finished divide or a single-cycle op, else drain/hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {(2*WIDTH){1'b0}};
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      err_r       <= 1'b0;
    end else if (state_r == DONE) begin
      out_valid_r <= 1'b1;
      result_r    <= {rem_r, quo_r};
      zero_r      <= ({rem_r, quo_r} == {(2*WIDTH){1'b0}});
      carry_r     <= 1'b0;
      err_r       <= 1'b0;
    end else if (accept_s && !start_div_s) begin
      out_valid_r <= 1'b1;
      result_r    <= calc_s.res;
      zero_r      <= (calc_s.res == {(2*WIDTH){1'b0}});
      carry_r     <= calc_s.cy;
      err_r       <= calc_s.er;
    end else if (start_div_s || out_ready) begin
      // Either the old result drains alongside a divide start, or it simply drains.
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule
